sdm_mash111: RTL and testbench

//  Third-order MASH 1-1-1 sigma-delta modulator for the fractional-N divider.

---
 rtl/sdm_mash111.sv | 133 +++++++++++++
 tb/tb_sdm_mash111.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sdm_mash111.sv
// Purpose : third-order MASH 1-1-1 sigma-delta modulator; turns a static fractional
//           word plus an integer part into a per-cycle divide ratio for a frac-N divider.
// Latency : 1 clk_ref from the accumulation edge to div_out/err_out (both on the same edge).
// Flow    : no backpressure; enable=0 freezes all state and outputs, err_valid drops to 0.
//
// Ports:
//   clk_ref   - reference clock, the only clock
//   rst       - asynchronous active-high reset
//   enable    - advance the modulator this cycle
//   frac_in   - unsigned fractional word (value frac_in/2^W)
//   frac_load - one-cycle strobe capturing frac_in (independent of enable)
//   int_in    - integer part of the divide ratio
//   div_out   - registered divide ratio, saturated to [0, 2^NI-1]
//   err_out   - registered stage-3 accumulator residue for the noise canceller
//   err_valid - div_out/err_out were updated on the last edge
//
// Build option: define SDM_DITHER_EN to add a 15-bit LFSR dither bit as the
// stage-1 carry-in. Without it the output sequence is fully deterministic.

module sdm_mash111 #(
   parameter int W  = 15,
   parameter int NI = 8
) (
   input  logic          clk_ref,
   input  logic          rst,
   input  logic          enable,
   input  logic [W-1:0]  frac_in,
   input  logic          frac_load,
   input  logic [NI-1:0] int_in,
   output logic [NI-1:0] div_out,
   output logic [W-1:0]  err_out,
   output logic          err_valid
);

   logic [W-1:0]  r_acc1;
   logic [W-1:0]  r_acc2;
   logic [W-1:0]  r_acc3;
   logic [W-1:0]  r_frac_act;
   logic          r_c2_d1;
   logic          r_c3_d1;
   logic          r_c3_d2;

   logic          w_d;
   logic [W:0]    w_s1;
   logic [W:0]    w_s2;
   logic [W:0]    w_s3;
   logic          w_c1;
   logic          w_c2;
   logic          w_c3;
   logic [3:0]    w_y;
   logic [NI+1:0] w_sum;
   logic [NI-1:0] w_div_sat;

`ifdef SDM_DITHER_EN
   // Fibonacci LFSR, x^15 + x^14 + 1; its LSB is the stage-1 carry-in.
   logic [14:0] r_lfsr;

   assign w_d = r_lfsr[0];

   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         r_lfsr <= 15'h4A5F;
      end else if (enable) begin
         r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
      end
   end
`else
   assign w_d = 1'b0;
`endif

   // Three cascaded accumulators; each stage integrates the previous residue.
   assign w_s1 = {1'b0, r_acc1} + {1'b0, r_frac_act} + {{W{1'b0}}, w_d};
   assign w_s2 = {1'b0, r_acc2} + {1'b0, w_s1[W-1:0]};
   assign w_s3 = {1'b0, r_acc3} + {1'b0, w_s2[W-1:0]};
   assign w_c1 = w_s1[W];
   assign w_c2 = w_s2[W];
   assign w_c3 = w_s3[W];

   // Noise-cancellation network: y = c1 + (1-z^-1)c2 + (1-z^-1)^2 c3.
   // Evaluated modulo 16 and read as 4-bit two's complement (range -3..+4).
   assign w_y = {3'b000, w_c1}
              + {3'b000, w_c2} - {3'b000, r_c2_d1}
              + {3'b000, w_c3} - {2'b00, r_c3_d1, 1'b0} + {3'b000, r_c3_d2};

   // Sign-extend y to NI+2 bits so int_in + y can never overflow before clamping.
   assign w_sum = {2'b00, int_in} + {{(NI-2){w_y[3]}}, w_y};

   always_comb begin
      w_div_sat = w_sum[NI-1:0];
      if (w_sum[NI+1]) begin
         w_div_sat = '0;              // negative: clamp to zero
      end else if (w_sum[NI]) begin
         w_div_sat = '1;              // above 2^NI-1: clamp to max
      end
   end

   // frac_act loads regardless of enable; the accumulation on the same edge
   // still sees the old word because it reads the register's current value.
   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         r_frac_act <= '0;
      end else if (frac_load) begin
         r_frac_act <= frac_in;
      end
   end

   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         r_acc1    <= '0;
         r_acc2    <= '0;
         r_acc3    <= '0;
         r_c2_d1   <= 1'b0;
         r_c3_d1   <= 1'b0;
         r_c3_d2   <= 1'b0;
         div_out   <= '0;
         err_out   <= '0;
         err_valid <= 1'b0;
      end else begin
         err_valid <= enable;
         if (enable) begin
            r_acc1  <= w_s1[W-1:0];
            r_acc2  <= w_s2[W-1:0];
            r_acc3  <= w_s3[W-1:0];
            r_c2_d1 <= w_c2;
            r_c3_d1 <= w_c3;
            r_c3_d2 <= r_c3_d1;
            div_out <= w_div_sat;
            err_out <= w_s3[W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_sdm_mash111.sv
module tb_sdm_mash111;

   localparam int W  = 15;
   localparam int NI = 8;

   logic          clk_ref;
   logic          rst;
   logic          enable;
   logic [W-1:0]  frac_in;
   logic          frac_load;
   logic [NI-1:0] int_in;
   logic [NI-1:0] div_out;
   logic [W-1:0]  err_out;
   logic          err_valid;

   int n_checks = 0;
   int n_errors = 0;

   sdm_mash111 #(.W(W), .NI(NI)) dut (
      .clk_ref   (clk_ref),
      .rst       (rst),
      .enable    (enable),
      .frac_in   (frac_in),
      .frac_load (frac_load),
      .int_in    (int_in),
      .div_out   (div_out),
      .err_out   (err_out),
      .err_valid (err_valid)
   );

   initial clk_ref = 1'b0;
   always #5 clk_ref = ~clk_ref;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int e_div, input int e_err, input int e_vld);
      chk({tag, ".div"}, int'(div_out), e_div);
      chk({tag, ".err"}, int'(err_out), e_err);
      chk({tag, ".vld"}, int'(err_valid), e_vld);
   endtask

   // Advance one edge; outputs are sampled and inputs driven 1 ns after it.
   task automatic step();
      @(posedge clk_ref);
      #1;
   endtask

   // Reset pulse placed between clock edges.
   task automatic rst_pulse(input string tag);
      step();
      #2 rst = 1'b1;
      #1 chk_out(tag, 0, 0, 0);
      #1 rst = 1'b0;
   endtask

   initial begin
      int sum;
      int bad;
      rst       = 1'b1;
      enable    = 1'b1;
      int_in    = 8'd40;
      frac_in   = '0;
      frac_load = 1'b0;

      // Reset state, including while clock runs with reset held
      #2 chk_out("reset", 0, 0, 0);
      step();
      chk_out("reset_held", 0, 0, 0);
      rst = 1'b0;

      // frac=0: div_out follows int_in, no residue
      for (int i = 0; i < 4; i++) begin
         step();
         chk_out($sformatf("zero_frac[%0d]", i), 40, 0, 1);
      end

      // Load 0.5; the loading edge still accumulates the old word (0)
      frac_in = 15'd16384; frac_load = 1'b1;
      step(); chk_out("half_e0", 40, 0, 1);
      frac_load = 1'b0;
      step(); chk_out("half_e1", 40, 16384, 1);
      step(); chk_out("half_e2", 42, 0, 1);

      // Pause: outputs frozen, err_valid low
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_out($sformatf("pause[%0d]", i), 42, 0, 0);
      end
      enable = 1'b1;
      // Resume continues the 40,42,39,41 cycle where it stopped
      step(); chk_out("resume_e3", 39, 0, 1);
      step(); chk_out("resume_e4", 41, 0, 1);
      step(); chk_out("resume_e5", 40, 16384, 1);
      step(); chk_out("resume_e6", 42, 0, 1);

      // 1024 cycles of period-4 sequence summing 162 -> 41472
      sum = 0; bad = 0;
      for (int i = 0; i < 1024; i++) begin
         step();
         sum += int'(div_out);
         if (div_out < 8'd37 || div_out > 8'd44) bad++;
      end
      chk("half_sum", sum, 41472);
      chk("half_range_viol", bad, 0);

      // Mid-cycle reset clears everything before the next edge
      rst_pulse("async_rst");

      // Rebuild zero state, run 0.5 then switch to 0.25 mid-run
      frac_in = 15'd16384; frac_load = 1'b1;
      step(); chk_out("r0", 40, 0, 1);
      frac_load = 1'b0;
      step(); chk_out("r1", 40, 16384, 1);
      step(); chk_out("r2", 42, 0, 1);
      step(); chk_out("r3", 39, 0, 1);
      step(); chk_out("r4", 41, 0, 1);
      frac_in = 15'd8192; frac_load = 1'b1;
      step(); chk_out("r5_old_word", 40, 16384, 1);
      frac_load = 1'b0;
      step(); chk_out("r6_new_word", 41, 24576, 1);
      step(); chk_out("r7", 41, 0, 1);
      // y = -2 here: 1 + (-2) clamps to 0
      int_in = 8'd1;
      step(); chk_out("r8_clamp_low", 0, 16384, 1);
      int_in = 8'd40;
      step(); chk_out("r9", 42, 16384, 1);

      // Near-full fraction at the top of the integer range
      rst_pulse("rst_hi");
      int_in = 8'd255; frac_in = 15'd32767; frac_load = 1'b1;
      step(); chk_out("hi_l0", 255, 0, 1);
      frac_load = 1'b0;
      step(); chk_out("hi_e1", 255, 32767, 1);
      step(); chk_out("hi_e2_clamp", 255, 32764, 1);
      step(); chk_out("hi_e3", 255, 32758, 1);
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (div_out < 8'd252) bad++;
      end
      chk("hi_no_wrap_viol", bad, 0);
      int_in = 8'd1;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (div_out > 8'd5) bad++;
      end
      chk("lo_no_wrap_viol", bad, 0);

      // Smallest fraction: long-run mean stays at 40 within 0.001
      rst_pulse("rst_lsb");
      int_in = 8'd40; frac_in = 15'd1; frac_load = 1'b1;
      step();
      frac_load = 1'b0;
      sum = 0;
      for (int i = 0; i < 40000; i++) begin
         step();
         sum += int'(div_out);
      end
      chk("lsb_mean_in_band", int'(sum >= 1599960 && sum <= 1600040), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
